aes_subword_seq: RTL and testbench

AES_SUBWORD_SEQ -- requirements
Module: aes_subword_seq

---
 rtl/aes_subword_seq_if.sv | 22 ++
 rtl/aes_subword_seq.sv | 134 +++++++++++++
 tb/tb_aes_subword_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_subword_seq_if.sv
// AES SubWord request/response bundle.
// master drives requests and out_ready; slave returns in_ready and results.
interface aes_subword_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        in_inv;
   logic        in_rot;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;

   modport master (
      output in_valid, in_word, in_inv, in_rot, out_ready,
      input  in_ready, out_valid, out_word
   );

   modport slave (
      input  in_valid, in_word, in_inv, in_rot, out_ready,
      output in_ready, out_valid, out_word
   );
endinterface

// File: rtl/aes_subword_seq.sv
// Sequential AES SubWord: one shared S-box, one byte per cycle, optional RotWord.
// Ports: g_clk, g_reset (async, active-high), bus (slave: request/response handshake).

// Byte S-box computed as GF(2^8) inverse plus affine map (forward),
// or inverse affine then GF inverse (inverse, only when DECRYPT_EN).
module aes_sbox #(
   parameter bit DECRYPT_EN = 1'b1
) (
   input  logic [7:0] din,
   input  logic       inv,
   output logic [7:0] dout
);
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 == x^-1 in GF(2^8); zero maps to zero.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] aff(input logic [7:0] a);
      return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]}
               ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] iaff(input logic [7:0] a);
      return {a[6:0], a[7]} ^ {a[4:0], a[7:5]}
           ^ {a[1:0], a[7:2]} ^ 8'h05;
   endfunction

   always_comb begin
      if (DECRYPT_EN && inv) dout = ginv(iaff(din));
      else                   dout = aff(ginv(din));
   end
endmodule

module aes_subword_seq #(
   parameter bit DECRYPT_EN = 1'b1
) (
   input  logic               g_clk,
   input  logic               g_reset,
   aes_subword_seq_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [1:0]  cnt;
   logic [31:0] wrd;
   logic        inv_q;
   logic        rot_q;
   logic        rdy_q;
   logic        vld_q;
   logic [31:0] out_q;
   logic [1:0]  idx;
   logic [7:0]  sb_in;
   logic [7:0]  sb_out;

   // RotWord is folded into the byte pick: effective byte i is raw byte i+1.
   assign idx   = cnt + {1'b0, rot_q};
   assign sb_in = wrd[{idx, 3'b000} +: 8];

   aes_sbox #(.DECRYPT_EN(DECRYPT_EN)) u_sbox (
      .din  (sb_in),
      .inv  (inv_q),
      .dout (sb_out)
   );

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state <= IDLE;
         cnt   <= 2'd0;
         wrd   <= 32'h0;
         inv_q <= 1'b0;
         rot_q <= 1'b0;
         rdy_q <= 1'b1;
         vld_q <= 1'b0;
         out_q <= 32'h0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  wrd   <= bus.in_word;
                  inv_q <= bus.in_inv;
                  rot_q <= bus.in_rot;
                  cnt   <= 2'd0;
                  rdy_q <= 1'b0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               out_q[{cnt, 3'b000} +: 8] <= sb_out;
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  vld_q <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  vld_q <= 1'b0;
                  rdy_q <= 1'b1;
                  state <= IDLE;
               end
            end
            default: begin
               vld_q <= 1'b0;
               rdy_q <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = rdy_q;
   assign bus.out_valid = vld_q;
   assign bus.out_word  = out_q;
endmodule

// File: tb/tb_aes_subword_seq.sv
// Scoreboard bench for aes_subword_seq: directed vectors plus random words.
// Expected words come from S-box tables built by a generator walk over GF(2^8).
module tb_aes_subword_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aes_subword_seq_if bus ();
   aes_subword_seq_if bus2 ();

   aes_subword_seq #(.DECRYPT_EN(1'b1)) dut (
      .g_clk   (clk),
      .g_reset (rst),
      .bus     (bus)
   );

   aes_subword_seq #(.DECRYPT_EN(1'b0)) dut_fwd (
      .g_clk   (clk),
      .g_reset (rst),
      .bus     (bus2)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   logic [31:0] expq[$];
   logic [7:0]  sb  [256];
   logic [7:0]  isb [256];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timeout got none expected event", name);
   endtask

   function automatic logic [7:0] rl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [31:0] model(input logic [31:0] w,
                                         input logic i, input logic r);
      logic [31:0] e;
      logic [31:0] res;
      logic [7:0]  v;
      e = r ? {w[7:0], w[31:8]} : w;
      res = 32'h0;
      for (int b = 0; b < 4; b++) begin
         v = e[8*b +: 8];
         res[8*b +: 8] = i ? isb[v] : sb[v];
      end
      return res;
   endfunction

   // Monitor: result compare, hold stability and accept-to-valid latency.
   logic        pend = 1'b0;
   logic        hold = 1'b0;
   int          acc  = 0;
   logic [31:0] prev = 32'h0;

   always @(negedge clk) begin
      if (rst) begin
         expq.delete();
         pend = 1'b0;
         hold = 1'b0;
      end else begin
         if (hold && bus.out_valid)
            chk("hold_stable", bus.out_word, prev);
         if (pend && bus.out_valid) begin
            chk("latency", 32'(cyc - acc), 32'd5);
            pend = 1'b0;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_result: got %h expected none",
                        bus.out_word);
            end else begin
               chk("result", bus.out_word, expq.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            acc  = cyc;
            pend = 1'b1;
         end
         hold = bus.out_valid && !bus.out_ready;
         prev = bus.out_word;
      end
   end

   task automatic xact(input logic [31:0] w, input logic i, input logic r,
                       input logic [31:0] exp, input int stall);
      bit ok;
      bus.in_word   = w;
      bus.in_inv    = i;
      bus.in_rot    = r;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      ok = 0;
      for (int k = 0; k < 10 && !ok; k++) begin
         @(posedge clk); #1;
         if (!bus.in_ready) ok = 1;
      end
      if (!ok) begin
         bus.in_valid = 1'b0;
         timeout("accept");
         return;
      end
      expq.push_back(exp);
      bus.in_valid = 1'b0;
      ok = 0;
      for (int k = 0; k < 10 && !ok; k++) begin
         if (bus.out_valid) begin
            ok = 1;
         end else begin
            bus.in_word = $urandom;
            bus.in_inv  = 1'($urandom_range(0, 1));
            bus.in_rot  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
      end
      if (!ok) begin
         timeout("out_valid");
         return;
      end
      for (int s = 0; s < stall; s++) begin
         bus.in_valid = 1'b1;
         bus.in_word  = $urandom;
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("idle_after_hs", {31'h0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      logic [7:0] p;
      logic [7:0] q;
      logic [7:0] x;
      bit         ok;
      logic [31:0] w;
      logic        ri;
      logic        rr;

      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
         sb[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
      for (int n = 0; n < 256; n++) isb[sb[n]] = 8'(n);

      bus.in_valid   = 1'b0;
      bus.in_word    = 32'h0;
      bus.in_inv     = 1'b0;
      bus.in_rot     = 1'b0;
      bus.out_ready  = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.in_word   = 32'h0;
      bus2.in_inv    = 1'b0;
      bus2.in_rot    = 1'b0;
      bus2.out_ready = 1'b0;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
      chk("rst_out_word", bus.out_word, 32'h0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);

      // DECRYPT_EN=0 instance must ignore the inverse request.
      bus2.in_word   = 32'h637C7763;
      bus2.in_inv    = 1'b1;
      bus2.in_valid  = 1'b1;
      bus2.out_ready = 1'b1;
      ok = 0;
      for (int k = 0; k < 12 && !ok; k++) begin
         @(posedge clk); #1;
         if (!bus2.in_ready) bus2.in_valid = 1'b0;
         if (bus2.out_valid) ok = 1;
      end
      if (ok) chk("fwd_only", bus2.out_word, 32'hFB10F5FB);
      else    timeout("fwd_only");
      bus2.in_valid = 1'b0;
      @(posedge clk); #1;
      bus2.out_ready = 1'b0;

      xact(32'h53020100, 1'b0, 1'b0, 32'hED777C63, 0);
      xact(32'h637C7763, 1'b1, 1'b0, 32'h00010200, 1);
      xact(32'h53020100, 1'b0, 1'b1, 32'h63ED777C, 2);
      xact(32'hA5C3_0F1E, 1'b0, 1'b0, model(32'hA5C30F1E, 1'b0, 1'b0), 5);

      // Reset in the BUSY cycle where byte 2 is being written.
      bus.in_word  = 32'hDEADBEEF;
      bus.in_inv   = 1'b0;
      bus.in_rot   = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", {31'h0, bus.out_valid}, 32'd0);
      chk("midrst_out_word", bus.out_word, 32'h0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", {31'h0, bus.in_ready}, 32'd1);
      @(posedge clk); #1;
      xact(32'h00000000, 1'b0, 1'b0, 32'h63636363, 0);

      for (int t = 0; t < 40; t++) begin
         w  = $urandom;
         ri = 1'($urandom_range(0, 1));
         rr = 1'($urandom_range(0, 1));
         xact(w, ri, rr, model(w, ri, rr), int'($urandom_range(0, 3)));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("drain", expq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
